// File: rtl/croc_pad_ctrl.sv
// croc_pad_ctrl: register-programmable pad controller.
// Per-pad GPIO/alternate-function output mux, 2-flop input synchroniser,
// per-pin programmable debounce and rise/fall edge interrupts, on the
// SoC's simple register bus (grant same cycle, response one cycle later).
module croc_pad_ctrl #(
  parameter int NumPads       = 24,
  parameter int DebounceWidth = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               reg_req_i,
  input  logic               reg_we_i,
  input  logic [5:0]         reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic               reg_gnt_o,
  output logic               reg_rvalid_o,
  output logic [31:0]        reg_rdata_o,
  output logic               reg_err_o,
  input  logic [NumPads-1:0] alt_o_i,
  input  logic [NumPads-1:0] alt_oe_i,
  input  logic [NumPads-1:0] pad_i,
  output logic [NumPads-1:0] pad_o,
  output logic [NumPads-1:0] pad_oe_o,
  output logic [NumPads-1:0] gpio_in_o,
  output logic               irq_o
);

  localparam logic [3:0] IdxDir    = 4'd0;
  localparam logic [3:0] IdxOut    = 4'd1;
  localparam logic [3:0] IdxIn     = 4'd2;
  localparam logic [3:0] IdxAltsel = 4'd3;
  localparam logic [3:0] IdxRiseEn = 4'd4;
  localparam logic [3:0] IdxFallEn = 4'd5;
  localparam logic [3:0] IdxStatus = 4'd6;
  localparam logic [3:0] IdxDbnc   = 4'd7;

  logic [NumPads-1:0] dir_q, dir_d;
  logic [NumPads-1:0] out_q, out_d;
  logic [NumPads-1:0] altsel_q, altsel_d;
  logic [NumPads-1:0] rise_en_q, rise_en_d;
  logic [NumPads-1:0] fall_en_q, fall_en_d;
  logic [NumPads-1:0] status_q, status_d;
  logic [DebounceWidth-1:0] debounce_q, debounce_d;

  logic [NumPads-1:0] sync1_q, sync2_q;
  logic [NumPads-1:0] din_q, din_d;
  logic [NumPads-1:0] prev_q;
  logic [DebounceWidth-1:0] cnt_q [NumPads];
  logic [DebounceWidth-1:0] cnt_d [NumPads];

  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [3:0]         reg_idx;
  logic               addr_bad;
  logic               wr_en;
  logic               dbnc_wr;
  logic [NumPads-1:0] w1c_mask;
  logic [NumPads-1:0] rise, fall;
  logic [DebounceWidth-1:0] dbnc_last;
  logic [NumPads-1:0] rd_pad;
  logic [31:0]        rd_word;
  logic               unused_bus;

  assign reg_idx   = reg_addr_i[5:2];
  assign addr_bad  = reg_idx[3];
  assign wr_en     = reg_req_i & reg_we_i & ~addr_bad;
  assign dbnc_wr   = wr_en & (reg_idx == IdxDbnc);
  assign w1c_mask  = (wr_en && reg_idx == IdxStatus) ? reg_wdata_i[NumPads-1:0] : '0;
  assign dbnc_last = debounce_q - DebounceWidth'(1);
  assign unused_bus = ^{reg_addr_i[1:0], reg_wdata_i};

  assign reg_gnt_o    = reg_req_i;
  assign reg_rvalid_o = rvalid_q;
  assign reg_rdata_o  = rdata_q;
  assign reg_err_o    = err_q;

  assign pad_o     = (altsel_q & alt_o_i)  | (~altsel_q & out_q);
  assign pad_oe_o  = (altsel_q & alt_oe_i) | (~altsel_q & dir_q);
  assign gpio_in_o = din_q;
  assign irq_o     = |status_q;

  assign rise = din_q & ~prev_q & rise_en_q;
  assign fall = ~din_q & prev_q & fall_en_q;

  // Configuration register writes and STATUS set/W1C (a new edge beats a clear).
  always_comb begin
    dir_d      = dir_q;
    out_d      = out_q;
    altsel_d   = altsel_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    debounce_d = debounce_q;
    status_d   = (status_q & ~w1c_mask) | rise | fall;
    if (wr_en) begin
      case (reg_idx)
        IdxDir:    dir_d      = reg_wdata_i[NumPads-1:0];
        IdxOut:    out_d      = reg_wdata_i[NumPads-1:0];
        IdxAltsel: altsel_d   = reg_wdata_i[NumPads-1:0];
        IdxRiseEn: rise_en_d  = reg_wdata_i[NumPads-1:0];
        IdxFallEn: fall_en_d  = reg_wdata_i[NumPads-1:0];
        IdxDbnc:   debounce_d = reg_wdata_i[DebounceWidth-1:0];
        default:   ;
      endcase
    end
  end

  // Debounce: sync must disagree with din for DEBOUNCE consecutive cycles.
  always_comb begin
    din_d = din_q;
    for (int i = 0; i < NumPads; i++) begin
      cnt_d[i] = cnt_q[i];
      if (dbnc_wr) begin
        cnt_d[i] = '0;
      end else if (debounce_q == '0) begin
        din_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else if (sync2_q[i] == din_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == dbnc_last) begin
        din_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DebounceWidth'(1);
      end
    end
  end

  // Read mux from pre-edge register values; response is registered.
  always_comb begin
    rd_pad  = '0;
    rd_word = '0;
    case (reg_idx)
      IdxDir:    rd_pad = dir_q;
      IdxOut:    rd_pad = out_q;
      IdxIn:     rd_pad = din_q;
      IdxAltsel: rd_pad = altsel_q;
      IdxRiseEn: rd_pad = rise_en_q;
      IdxFallEn: rd_pad = fall_en_q;
      IdxStatus: rd_pad = status_q;
      default:   rd_pad = '0;
    endcase
    rd_word[NumPads-1:0] = rd_pad;
    if (reg_idx == IdxDbnc) rd_word[DebounceWidth-1:0] = debounce_q;
    rvalid_d = reg_req_i;
    err_d    = reg_req_i & addr_bad;
    rdata_d  = (reg_req_i && !reg_we_i && !addr_bad) ? rd_word : '0;
  end

  // All state flops; async reset releases pads and drops pending responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dir_q      <= '0;
      out_q      <= '0;
      altsel_q   <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      debounce_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      din_q      <= '0;
      prev_q     <= '0;
      for (int i = 0; i < NumPads; i++) cnt_q[i] <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      dir_q      <= dir_d;
      out_q      <= out_d;
      altsel_q   <= altsel_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      status_q   <= status_d;
      debounce_q <= debounce_d;
      sync1_q    <= pad_i;
      sync2_q    <= sync1_q;
      din_q      <= din_d;
      prev_q     <= din_q;
      cnt_q      <= cnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_croc_pad_ctrl.sv
// Testbench for croc_pad_ctrl: behavioural model + response scoreboard,
// directed scenarios followed by randomized bus/pad traffic.
module tb_croc_pad_ctrl;
  localparam int NP = 24;
  localparam int DW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          reg_req_i = 1'b0;
  logic          reg_we_i = 1'b0;
  logic [5:0]    reg_addr_i = '0;
  logic [31:0]   reg_wdata_i = '0;
  logic          reg_gnt_o, reg_rvalid_o, reg_err_o;
  logic [31:0]   reg_rdata_o;
  logic [NP-1:0] alt_o_i = '0, alt_oe_i = '0, pad_i = '0;
  logic [NP-1:0] pad_o, pad_oe_o, gpio_in_o;
  logic          irq_o;

  croc_pad_ctrl #(.NumPads(NP), .DebounceWidth(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .reg_req_i(reg_req_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i),
    .reg_wdata_i(reg_wdata_i), .reg_gnt_o(reg_gnt_o), .reg_rvalid_o(reg_rvalid_o),
    .reg_rdata_o(reg_rdata_o), .reg_err_o(reg_err_o),
    .alt_o_i(alt_o_i), .alt_oe_i(alt_oe_i), .pad_i(pad_i),
    .pad_o(pad_o), .pad_oe_o(pad_oe_o), .gpio_in_o(gpio_in_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct { bit is_rd; logic [31:0] rdata; bit err; } resp_t;
  resp_t exp_q[$];
  logic [NP-1:0] m_dir, m_out, m_alt, m_ren, m_fen, m_status, m_din, m_prev;
  int            m_dbn;
  int            m_run [NP];
  logic [NP-1:0] pad_dly[$];

  function automatic logic [31:0] m_read(input int idx);
    case (idx)
      0: return 32'(m_dir);
      1: return 32'(m_out);
      2: return 32'(m_din);
      3: return 32'(m_alt);
      4: return 32'(m_ren);
      5: return 32'(m_fen);
      6: return 32'(m_status);
      7: return 32'(m_dbn);
      default: return 32'h0;
    endcase
  endfunction

  // Model: one step per clock edge, from the pre-edge model state and inputs.
  always @(posedge clk_i or negedge rst_ni) begin : model
    logic [NP-1:0] sync_v, rise_v, fall_v, w1c_v, din_n;
    int idx;
    resp_t r;
    if (!rst_ni) begin
      m_dir = '0; m_out = '0; m_alt = '0; m_ren = '0; m_fen = '0;
      m_status = '0; m_din = '0; m_prev = '0; m_dbn = 0;
      for (int i = 0; i < NP; i++) m_run[i] = 0;
      pad_dly.delete();
      pad_dly.push_back('0);
      pad_dly.push_back('0);
      exp_q.delete();
    end else begin
      idx = int'(reg_addr_i[5:2]);
      if (reg_req_i) begin
        r.is_rd = !reg_we_i;
        r.err   = (idx >= 8);
        r.rdata = (!reg_we_i && idx < 8) ? m_read(idx) : 32'h0;
        exp_q.push_back(r);
      end
      sync_v = pad_dly.pop_front();
      pad_dly.push_back(pad_i);
      rise_v = m_din & ~m_prev & m_ren;
      fall_v = ~m_din & m_prev & m_fen;
      w1c_v  = (reg_req_i && reg_we_i && idx == 6) ? reg_wdata_i[NP-1:0] : '0;
      din_n  = m_din;
      if (reg_req_i && reg_we_i && idx == 7) begin
        for (int i = 0; i < NP; i++) m_run[i] = 0;
      end else if (m_dbn == 0) begin
        din_n = sync_v;
      end else begin
        for (int i = 0; i < NP; i++) begin
          if (sync_v[i] != m_din[i]) begin
            m_run[i]++;
            if (m_run[i] >= m_dbn) begin
              din_n[i] = sync_v[i];
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      m_prev   = m_din;
      m_din    = din_n;
      m_status = (m_status & ~w1c_v) | rise_v | fall_v;
      if (reg_req_i && reg_we_i) begin
        case (idx)
          0: m_dir = reg_wdata_i[NP-1:0];
          1: m_out = reg_wdata_i[NP-1:0];
          3: m_alt = reg_wdata_i[NP-1:0];
          4: m_ren = reg_wdata_i[NP-1:0];
          5: m_fen = reg_wdata_i[NP-1:0];
          7: m_dbn = int'(reg_wdata_i[DW-1:0]);
          default: ;
        endcase
      end
    end
  end

  // Monitor: compare outputs and pop responses on the falling edge.
  always @(negedge clk_i) begin : monitor
    resp_t r;
    if (rst_ni) begin
      check("pad_o", 32'(pad_o), 32'((m_alt & alt_o_i) | (~m_alt & m_out)));
      check("pad_oe_o", 32'(pad_oe_o), 32'((m_alt & alt_oe_i) | (~m_alt & m_dir)));
      check("gpio_in_o", 32'(gpio_in_o), 32'(m_din));
      check("irq_o", 32'(irq_o), 32'(|m_status));
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        check("rvalid", 32'(reg_rvalid_o), 32'h1);
        check("err", 32'(reg_err_o), 32'(r.err));
        if (r.is_rd) check("rdata", reg_rdata_o, r.rdata);
      end else begin
        check("rvalid_idle", 32'(reg_rvalid_o), 32'h0);
      end
    end
  end

  // Bus access: called 2 time units after a rising edge, returns likewise.
  task automatic bus_op(input bit we, input logic [5:0] a, input logic [31:0] d);
    reg_req_i = 1'b1; reg_we_i = we; reg_addr_i = a; reg_wdata_i = d;
    check("gnt", 32'(reg_gnt_o), 32'h1);
    @(posedge clk_i); #2;
    reg_req_i = 1'b0; reg_we_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #2; end
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    idle(2);
    check("reset_pad_oe", 32'(pad_oe_o), 32'h0);
    check("reset_irq", 32'(irq_o), 32'h0);

    // GPIO drive, then alternate function takes over pad 0
    bus_op(1, 6'h00, 32'h1);
    bus_op(1, 6'h04, 32'h1);
    check("gpio_pad_o0", 32'(pad_o[0]), 32'h1);
    check("gpio_pad_oe0", 32'(pad_oe_o[0]), 32'h1);
    alt_o_i[0] = 1'b0; alt_oe_i[0] = 1'b1;
    bus_op(1, 6'h0C, 32'h1);
    check("alt_pad_o0", 32'(pad_o[0]), 32'h0);
    check("alt_pad_oe0", 32'(pad_oe_o[0]), 32'h1);
    bus_op(1, 6'h0C, 32'h0);

    // Rising edge interrupt without debounce
    bus_op(1, 6'h10, 32'h4);
    pad_i[2] = 1'b1;
    idle(5);
    check("rise_in2", 32'(gpio_in_o[2]), 32'h1);
    check("rise_irq", 32'(irq_o), 32'h1);
    bus_op(0, 6'h18, 32'h0);
    bus_op(1, 6'h18, 32'h4);
    check("w1c_irq", 32'(irq_o), 32'h0);
    pad_i[2] = 1'b0;
    idle(5);
    check("nofall_irq", 32'(irq_o), 32'h0);

    // Debounce: 3-cycle glitch rejected, long low accepted
    bus_op(1, 6'h1C, 32'h4);
    bus_op(1, 6'h14, 32'h1);
    pad_i[0] = 1'b1;
    idle(10);
    check("dbn_hi_in0", 32'(gpio_in_o[0]), 32'h1);
    check("dbn_hi_irq", 32'(irq_o), 32'h0);
    pad_i[0] = 1'b0; idle(3); pad_i[0] = 1'b1;
    idle(8);
    check("glitch_in0", 32'(gpio_in_o[0]), 32'h1);
    check("glitch_irq", 32'(irq_o), 32'h0);
    pad_i[0] = 1'b0;
    idle(10);
    check("dbn_lo_in0", 32'(gpio_in_o[0]), 32'h0);
    check("dbn_lo_irq", 32'(irq_o), 32'h1);
    bus_op(0, 6'h08, 32'h0);
    bus_op(1, 6'h18, 32'hFFFF_FFFF);
    bus_op(1, 6'h1C, 32'h0);
    bus_op(1, 6'h14, 32'h0);

    // Edge-set beats simultaneous W1C
    bus_op(1, 6'h10, 32'h20);
    pad_i[5] = 1'b1; idle(5);
    pad_i[5] = 1'b0; idle(5);
    bus_op(1, 6'h18, 32'h20);
    check("sw_cleared_irq", 32'(irq_o), 32'h0);
    pad_i[5] = 1'b1;
    idle(3);
    bus_op(1, 6'h18, 32'h20);
    check("setwins_irq", 32'(irq_o), 32'h1);
    idle(2);
    check("setwins_irq_hold", 32'(irq_o), 32'h1);
    bus_op(0, 6'h18, 32'h0);
    bus_op(1, 6'h18, 32'hFFFF_FFFF);
    bus_op(1, 6'h10, 32'h0);

    // Unmapped accesses and back-to-back reads
    bus_op(0, 6'h20, 32'h0);
    bus_op(1, 6'h3C, 32'hFFFF_FFFF);
    for (int a = 0; a < 8; a++) bus_op(0, 6'(a * 4), 32'h0);
    bus_op(0, 6'h00, 32'h0);
    bus_op(0, 6'h04, 32'h0);

    // Asynchronous reset mid-run with pads driven and irq pending
    bus_op(1, 6'h00, 32'hFF_FFFF);
    bus_op(1, 6'h10, 32'h8);
    pad_i[3] = 1'b1;
    idle(5);
    check("pre_rst_oe", 32'(pad_oe_o), 32'hFF_FFFF);
    check("pre_rst_irq", 32'(irq_o), 32'h1);
    reg_req_i = 1'b1; reg_we_i = 1'b0; reg_addr_i = 6'h00;
    @(posedge clk_i); #1;
    reg_req_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check("rst_oe", 32'(pad_oe_o), 32'h0);
    check("rst_irq", 32'(irq_o), 32'h0);
    check("rst_rvalid", 32'(reg_rvalid_o), 32'h0);
    pad_i = '0;
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    for (int a = 0; a < 8; a++) bus_op(0, 6'(a * 4), 32'h0);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      logic [5:0]  ra;
      logic [31:0] rd;
      pad_i    = pad_i ^ NP'($urandom & $urandom & $urandom);
      alt_o_i  = NP'($urandom);
      alt_oe_i = NP'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        ra = 6'($urandom_range(0, 63));
        rd = $urandom;
        if (ra[5:2] == 4'd7) rd = 32'($urandom_range(0, 5));
        bus_op(1'($urandom_range(0, 1)), ra, rd);
      end else begin
        idle(1);
      end
    end
    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
